data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_line_array.sv | 56 +++++
 rtl/data_cache.sv | 176 +++++++++++++++++
 tb/tb_data_cache.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing constants for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned STAT_W          = 16;
  localparam int unsigned DEF_NUM_LINES   = 8;
  localparam int unsigned DEF_MEM_LATENCY = 4;
  localparam int unsigned DEF_INDEX_W     = $clog2(DEF_NUM_LINES);
  localparam int unsigned DEF_TAG_W       = ADDR_W - DEF_INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_MISS = 2'd1,
    ST_WRITE     = 2'd2
  } state_e;

  // Latency counter width; a one-cycle memory still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: one synchronous write port, asynchronous read port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEF_NUM_LINES,
  parameter int unsigned INDEX_W   = DEF_INDEX_W,
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter int unsigned LINE_W    = DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // A write always leaves the addressed line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) begin
      valid_d[wr_index_i] = 1'b1;
    end
  end

  // Valid bits are the only storage cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data payload, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && !reset) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES   = DEF_NUM_LINES,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
  localparam int unsigned CNT_W   = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAT_W-1:0]  hit_count_q, hit_count_d;
  logic [STAT_W-1:0]  miss_count_q, miss_count_d;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               hit;
  logic               last_cycle;

  logic               fill_we_c;
  logic [DATA_W-1:0]  fill_data_c;
  logic               hit_inc_c;
  logic               miss_inc_c;
  logic               stall_c;
  logic               mem_we_c;
  logic [DATA_W-1:0]  cpu_rdata_c;

  assign index      = cpu_addr[INDEX_W-1:0];
  assign tag        = cpu_addr[ADDR_W-1:INDEX_W];
  assign hit        = line_valid && (line_tag == tag);
  assign last_cycle = (cnt_q == CNT_LAST);

  cache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (DATA_W)
  ) u_lines (
    .clk        (clk),
    .reset      (reset),
    .rd_index_i (index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (fill_we_c),
    .wr_index_i (index),
    .wr_tag_i   (tag),
    .wr_data_i  (fill_data_c)
  );

  // State, latency counter and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next-state, handshake and line-update decode; reset overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    stall_c     = 1'b0;
    mem_we_c    = 1'b0;
    cpu_rdata_c = '0;
    fill_we_c   = 1'b0;
    fill_data_c = mem_rdata;
    hit_inc_c   = 1'b0;
    miss_inc_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            stall_c = 1'b1;
            state_d = ST_WRITE;
          end else if (hit) begin
            cpu_rdata_c = line_data;
            hit_inc_c   = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = ST_READ_MISS;
          end
        end
      end
      ST_READ_MISS: begin
        if (last_cycle) begin
          cpu_rdata_c = mem_rdata;
          fill_we_c   = 1'b1;
          fill_data_c = mem_rdata;
          miss_inc_c  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (last_cycle) begin
          mem_we_c    = 1'b1;
          fill_we_c   = hit;
          fill_data_c = cpu_wdata;
          state_d     = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reset) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      stall_c     = 1'b0;
      mem_we_c    = 1'b0;
      cpu_rdata_c = '0;
      fill_we_c   = 1'b0;
      hit_inc_c   = 1'b0;
      miss_inc_c  = 1'b0;
    end
  end

  // Saturating load statistics.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_inc_c && (hit_count_q != STAT_MAX)) begin
      hit_count_d = hit_count_q + STAT_W'(1);
    end
    if (miss_inc_c && (miss_count_q != STAT_MAX)) begin
      miss_count_d = miss_count_q + STAT_W'(1);
    end
  end

  assign cpu_rdata  = cpu_rdata_c;
  assign stall      = stall_c;
  assign mem_we     = mem_we_c;
  assign mem_addr   = cpu_addr;
  assign mem_wdata  = cpu_wdata;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus random traffic against a cache model.
module tb_data_cache;

  localparam int unsigned NL        = 8;
  localparam int unsigned ML        = 4;
  localparam int unsigned MEM_WORDS = 64;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  // Backing memory seen by the DUT
  logic [31:0] mem [MEM_WORDS];
  // Reference model: expected memory image and cache contents keyed by full address
  logic [31:0] ref_mem   [MEM_WORDS];
  bit          ref_valid [NL];
  logic [31:0] ref_addr  [NL];
  logic [31:0] ref_data  [NL];
  int          ref_hits;
  int          ref_misses;

  data_cache #(.NUM_LINES(NL), .MEM_LATENCY(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[cpu_addr[5:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
  end

  function automatic void model_reset();
    for (int i = 0; i < int'(NL); i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_counters(input string name);
    checks++;
    if (hit_count !== 16'(ref_hits) || miss_count !== 16'(ref_misses)) begin
      errors++;
      $display("FAIL %s counters: hit=%0d miss=%0d expected hit=%0d miss=%0d",
               name, hit_count, miss_count, ref_hits, ref_misses);
    end
  endtask

  // One complete CPU request, started and finished on a falling edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string name);
    int unsigned idx;
    int unsigned stalls, pulses, exp_stalls;
    bit          hit, done, stray, final_we;
    logic [31:0] exp_rdata, got;
    idx        = addr % NL;
    hit        = ref_valid[idx] && (ref_addr[idx] == addr);
    exp_stalls = (!we && hit) ? 0 : ML;
    exp_rdata  = we ? 32'd0 : (hit ? ref_data[idx] : ref_mem[addr % MEM_WORDS]);

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stalls = 0; pulses = 0; done = 0; stray = 0; final_we = 0; got = '0;
    for (int c = 0; c < int'(4 * ML + 8); c++) begin
      #1;
      if (mem_we === 1'b1) pulses++;
      if (stall === 1'b0) begin
        got      = cpu_rdata;
        final_we = (mem_we === 1'b1);
        done     = 1;
        break;
      end
      if (cpu_rdata !== 32'd0) stray = 1;
      stalls++;
      @(negedge clk);
    end

    checks++;
    if (!done || stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d (done=%0d) expected %0d", name, stalls, done, exp_stalls);
    end
    checks++;
    if (got !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata: got %08h expected %08h", name, got, exp_rdata);
    end
    checks++;
    if (pulses != (we ? 1 : 0) || final_we != we) begin
      errors++;
      $display("FAIL %s mem_we: pulses %0d final %0d expected pulses %0d", name, pulses, final_we, we);
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL %s rdata_while_stalled: nonzero, expected 0", name);
    end

    if (we) begin
      ref_mem[addr % MEM_WORDS] = wdata;
      if (hit) ref_data[idx] = wdata;
    end else if (hit) begin
      ref_hits++;
    end else begin
      ref_misses++;
      ref_valid[idx] = 1'b1;
      ref_addr[idx]  = addr;
      ref_data[idx]  = ref_mem[addr % MEM_WORDS];
    end

    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    #1;
    check_counters(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset     = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'd5;
    cpu_wdata = 32'h0BAD_0BAD;
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs: stall=%b mem_we=%b rdata=%08h expected 0 0 0", stall, mem_we, cpu_rdata);
      end
    end
    @(negedge clk);
    reset   = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    model_reset();
    #1;
    check_counters("reset");
    checks++;
    if (stall !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL idle_outputs: stall=%b mem_we=%b rdata=%08h expected 0 0 0", stall, mem_we, cpu_rdata);
    end
  endtask

  task automatic test_miss_then_hit();
    access(1'b0, 32'd5, 32'd0, "load5_miss");
    access(1'b0, 32'd5, 32'd0, "load5_hit");
    checks++;
    if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL miss_then_hit_counts: hit=%0d miss=%0d expected 1 1", hit_count, miss_count);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    access(1'b0, 32'd5,  32'd0, "conflict_5a");
    access(1'b0, 32'd13, 32'd0, "conflict_13");
    access(1'b0, 32'd5,  32'd0, "conflict_5b");
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd3) begin
      errors++;
      $display("FAIL conflict_counts: hit=%0d miss=%0d expected 0 3", hit_count, miss_count);
    end
  endtask

  task automatic test_store_hit();
    access(1'b1, 32'd5, 32'h1234_5678, "store5_hit");
    access(1'b0, 32'd5, 32'd0,         "load5_after_store");
  endtask

  task automatic test_store_miss();
    access(1'b1, 32'd20, 32'hA5A5_A5A5, "store20_miss");
    access(1'b0, 32'd20, 32'd0,         "load20_after_store");
  endtask

  task automatic test_reset_abort();
    logic [31:0] before9;
    bit          saw_we;
    do_reset();
    saw_we    = 0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd7;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      #1;
      if (mem_we !== 1'b0 || stall !== 1'b0) saw_we = 1;
      @(negedge clk);
    end
    reset   = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    checks++;
    if (saw_we) begin
      errors++;
      $display("FAIL abort_load_outputs: stall or mem_we high during reset, expected low");
    end
    #1;
    check_counters("abort_load");

    before9   = ref_mem[9];
    saw_we    = 0;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'd9;
    cpu_wdata = 32'hFEED_F00D;
    repeat (3) begin
      #1;
      if (mem_we !== 1'b0) saw_we = 1;
      @(negedge clk);
    end
    reset = 1'b1;
    repeat (2) begin
      #1;
      if (mem_we !== 1'b0) saw_we = 1;
      @(negedge clk);
    end
    reset   = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    model_reset();
    #1;
    checks++;
    if (saw_we || mem[9] !== before9) begin
      errors++;
      $display("FAIL abort_store: mem_we seen=%0d mem[9]=%08h expected 0 %08h", saw_we, mem[9], before9);
    end
    @(negedge clk);
    access(1'b0, 32'd7, 32'd0, "load7_after_abort");
    checks++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL abort_followup_counts: hit=%0d miss=%0d expected 0 1", hit_count, miss_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq[0] = 32'd3; seq[1] = 32'd12; seq[2] = 32'd3;
    access(1'b0, 32'd3,  32'd0, "b2b_fill3");
    access(1'b0, 32'd12, 32'd0, "b2b_fill12");
    cpu_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_req  = 1'b1;
      cpu_addr = seq[i];
      #1;
      checks++;
      if (stall !== 1'b0 || cpu_rdata !== ref_data[seq[i] % NL]) begin
        errors++;
        $display("FAIL b2b_hit%0d: stall=%b rdata=%08h expected 0 %08h", i, stall, cpu_rdata, ref_data[seq[i] % NL]);
      end
      ref_hits++;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    #1;
    check_counters("b2b");
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr;
    for (int n = 0; n < 80; n++) begin
      we   = ($urandom_range(0, 2) == 0);
      addr = 32'($urandom_range(0, 31));
      access(we, addr, $urandom, "random");
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== 32'd0) begin
          errors++;
          $display("FAIL random_idle: stall=%b mem_we=%b rdata=%08h expected 0 0 0", stall, mem_we, cpu_rdata);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5]      = 32'hDEAD_BEEF;
    ref_mem[5]  = 32'hDEAD_BEEF;
    model_reset();

    test_reset();
    test_miss_then_hit();
    test_conflict();
    test_store_hit();
    test_store_miss();
    test_reset_abort();
    test_back_to_back();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
